switch_debounce_ctrl: RTL and testbench

SWITCH_DEBOUNCE_CTRL -- requirements
Module: switch_debounce_ctrl

---
 rtl/switch_debounce_ctrl_pkg.sv | 26 ++
 rtl/switch_debounce_ctrl_if.sv | 37 +++
 rtl/debounce_filter.sv | 46 ++++
 rtl/switch_debounce_ctrl.sv | 59 +++++
 tb/tb_switch_debounce_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_debounce_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_debounce_ctrl_pkg - shared debounce constants and channel map     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package switch_debounce_ctrl_pkg;

  // 250 cycles of a 25 kHz clock gives a 10 ms stability window.
  localparam int unsigned C_DEBOUNCE_LIMIT_DEFAULT = 250;

  localparam int CH_SWITCH_1  = 0;
  localparam int CH_SWITCH_2  = 1;
  localparam int CH_BUTTON    = 2;
  localparam int NUM_CHANNELS = 3;

  typedef logic [NUM_CHANNELS-1:0] channel_vec_t;

  // Counter only has to reach limit-1; guard the limit=2 corner where $clog2 gives 1 anyway.
  function automatic int debounce_cnt_width(input int unsigned limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

  localparam int C_DEBOUNCE_CNT_W = debounce_cnt_width(C_DEBOUNCE_LIMIT_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/switch_debounce_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_debounce_ctrl_if - raw switch pins in, debounced controls out     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface switch_debounce_ctrl_if;

  logic i_switch_1_raw;
  logic i_switch_2_raw;
  logic i_button_raw;
  logic o_switch_1;
  logic o_switch_2;
  logic o_enable;
  logic o_sel_change;

  modport master (
    output i_switch_1_raw,
    output i_switch_2_raw,
    output i_button_raw,
    input  o_switch_1,
    input  o_switch_2,
    input  o_enable,
    input  o_sel_change
  );

  modport slave (
    input  i_switch_1_raw,
    input  i_switch_2_raw,
    input  i_button_raw,
    output o_switch_1,
    output o_switch_2,
    output o_enable,
    output o_sel_change
  );

endinterface
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_filter - one channel: 2-flop synchronizer, run counter, state   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module debounce_filter
  import switch_debounce_ctrl_pkg::*;
#(
  parameter int unsigned c_DEBOUNCE_LIMIT = C_DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int               CNT_W    = debounce_cnt_width(c_DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(c_DEBOUNCE_LIMIT - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] count;

  // Any sample matching the accepted level restarts the run, so short glitches never accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      count  <= '0;
      stable <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == stable) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        stable <= ~stable;
        count  <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/switch_debounce_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_debounce_ctrl - debounces two selector switches and a button      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module switch_debounce_ctrl
  import switch_debounce_ctrl_pkg::*;
#(
  parameter int unsigned c_DEBOUNCE_LIMIT = C_DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  switch_debounce_ctrl_if.slave bus
);

  channel_vec_t raw;
  channel_vec_t debounced;
  channel_vec_t debounced_q;
  logic         enable;
  logic         sel_change;

  assign raw[CH_SWITCH_1] = bus.i_switch_1_raw;
  assign raw[CH_SWITCH_2] = bus.i_switch_2_raw;
  assign raw[CH_BUTTON]   = bus.i_button_raw;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_channel
    debounce_filter #(
      .c_DEBOUNCE_LIMIT(c_DEBOUNCE_LIMIT)
    ) u_filter (
      .clk   (i_clock),
      .rst   (i_reset),
      .raw   (raw[ch]),
      .stable(debounced[ch])
    );
  end

  // Edge-detect history is cleared with the filters, so leaving reset never looks like a change.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      debounced_q <= '0;
      enable      <= 1'b0;
      sel_change  <= 1'b0;
    end else begin
      debounced_q <= debounced;
      sel_change  <= (debounced[CH_SWITCH_1] ^ debounced_q[CH_SWITCH_1]) |
                     (debounced[CH_SWITCH_2] ^ debounced_q[CH_SWITCH_2]);
      if (debounced[CH_BUTTON] && !debounced_q[CH_BUTTON]) begin
        enable <= ~enable;
      end
    end
  end

  assign bus.o_switch_1   = debounced[CH_SWITCH_1];
  assign bus.o_switch_2   = debounced[CH_SWITCH_2];
  assign bus.o_enable     = enable;
  assign bus.o_sel_change = sel_change;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_switch_debounce_ctrl - directed and random checks against a model     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_switch_debounce_ctrl;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] drv_raw = 3'b000;  // bit0 switch 1, bit1 switch 2, bit2 button
  logic [3:0] act;

  int compared   = 0;
  int mismatched = 0;

  switch_debounce_ctrl_if dif ();

  assign dif.i_switch_1_raw = drv_raw[0];
  assign dif.i_switch_2_raw = drv_raw[1];
  assign dif.i_button_raw   = drv_raw[2];
  assign act = {dif.o_switch_1, dif.o_switch_2, dif.o_enable, dif.o_sel_change};

  switch_debounce_ctrl #(
    .c_DEBOUNCE_LIMIT(L)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (dif)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last L samples seen (two edges late,
  // forced low around reset) all disagree with the accepted level.
  logic       m_rst_h1 = 1'b1, m_rst_h2 = 1'b1;
  logic [2:0] m_raw_h1 = '0, m_raw_h2 = '0;
  logic [2:0] m_st = '0, m_st_prev = '0;
  logic       m_en = 1'b0, m_sel = 1'b0;
  bit         hist [3][$];

  function automatic logic [3:0] model_vec();
    return {m_st[0], m_st[1], m_en, m_sel};
  endfunction

  task automatic step();
    logic [2:0] raw_now, st_new;
    logic       rst_now, smp, all_diff;
    raw_now = drv_raw;
    rst_now = rst;
    @(posedge clk);
    #1;
    st_new = m_st;
    if (rst_now) begin
      st_new = '0;
      m_sel  = 1'b0;
      m_en   = 1'b0;
      for (int c = 0; c < 3; c++) hist[c].delete();
    end else begin
      for (int c = 0; c < 3; c++) begin
        smp = (m_rst_h1 || m_rst_h2) ? 1'b0 : m_raw_h2[c];
        hist[c].push_back(smp);
        if (hist[c].size() > L) void'(hist[c].pop_front());
        all_diff = (hist[c].size() == L);
        foreach (hist[c][k]) if (hist[c][k] == m_st[c]) all_diff = 1'b0;
        if (all_diff) begin
          st_new[c] = ~m_st[c];
          hist[c].delete();
        end
      end
      m_sel = !m_rst_h1 && ((m_st[0] != m_st_prev[0]) || (m_st[1] != m_st_prev[1]));
      if (!m_rst_h1 && m_st[2] && !m_st_prev[2]) m_en = ~m_en;
    end
    m_st_prev = m_st;
    m_st      = st_new;
    m_raw_h2  = m_raw_h1;
    m_raw_h1  = raw_now;
    m_rst_h2  = m_rst_h1;
    m_rst_h1  = rst_now;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    drv_raw = 3'b000;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_raw = 3'($urandom);
      step();
      compared++;
      if (act !== 4'b0000) begin
        mismatched++;
        $display("FAIL reset cycle %0d: got %b, want 0000", i, act);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_switch1_latency();
    do_reset();
    drv_raw = 3'b001;
    for (int e = 1; e <= 10; e++) begin
      step();
      compared++;
      if (dif.o_switch_1 !== (e >= 6) || dif.o_sel_change !== (e == 7)) begin
        mismatched++;
        $display("FAIL sw1_latency edge %0d: got sw1=%b sel=%b, want sw1=%b sel=%b",
                 e, dif.o_switch_1, dif.o_sel_change, e >= 6, e == 7);
      end
      compared++;
      if (act !== model_vec()) begin
        mismatched++;
        $display("FAIL sw1_latency_model edge %0d: got %b, want %b", e, act, model_vec());
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    drv_raw = 3'b010;
    for (int e = 1; e <= 15; e++) begin
      if (e == 4) drv_raw = 3'b000;
      step();
      compared++;
      if (dif.o_switch_2 !== 1'b0 || dif.o_sel_change !== 1'b0 || act !== model_vec()) begin
        mismatched++;
        $display("FAIL glitch edge %0d: got %b, want sw2=0 sel=0 (model %b)", e, act, model_vec());
      end
    end
  endtask

  task automatic test_button();
    do_reset();
    for (int phase = 0; phase < 3; phase++) begin
      drv_raw = (phase == 1) ? 3'b000 : 3'b100;
      for (int e = 1; e <= 10; e++) begin
        logic want;
        step();
        case (phase)
          0:       want = (e >= 7);
          1:       want = 1'b1;
          default: want = (e < 7);
        endcase
        compared++;
        if (dif.o_enable !== want || act !== model_vec()) begin
          mismatched++;
          $display("FAIL button phase %0d edge %0d: got en=%b (%b), want en=%b (%b)",
                   phase, e, dif.o_enable, act, want, model_vec());
        end
      end
    end
  endtask

  task automatic test_both_switches();
    int pulses = 0;
    do_reset();
    drv_raw = 3'b011;
    for (int e = 1; e <= 12; e++) begin
      step();
      pulses += int'(dif.o_sel_change);
      compared++;
      if (act !== {e >= 6, e >= 6, 1'b0, e == 7}) begin
        mismatched++;
        $display("FAIL both_switches edge %0d: got %b, want %b", e, act,
                 {e >= 6, e >= 6, 1'b0, e == 7});
      end
    end
    compared++;
    if (pulses != 1) begin
      mismatched++;
      $display("FAIL both_switches_pulses: got %0d, want 1", pulses);
    end
  endtask

  task automatic test_press_and_switch();
    do_reset();
    drv_raw = 3'b101;
    for (int e = 1; e <= 10; e++) begin
      step();
      compared++;
      if (act !== {e >= 6, 1'b0, e >= 7, e == 7}) begin
        mismatched++;
        $display("FAIL press_and_switch edge %0d: got %b, want %b", e, act,
                 {e >= 6, 1'b0, e >= 7, e == 7});
      end
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    drv_raw = 3'b001;
    repeat (4) step();
    rst = 1'b1;
    step();
    compared++;
    if (act !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_mid_count in reset: got %b, want 0000", act);
    end
    rst = 1'b0;
    for (int e = 6; e <= 16; e++) begin
      step();
      compared++;
      if (dif.o_switch_1 !== (e >= 11) || dif.o_sel_change !== (e == 12) || act !== model_vec()) begin
        mismatched++;
        $display("FAIL reset_mid_count edge %0d: got %b, want sw1=%b sel=%b (model %b)",
                 e, act, e >= 11, e == 12, model_vec());
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pattern;
    pattern = 5'b10101;
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      drv_raw = (e <= 5) ? {2'b00, pattern[e-1]} : 3'b001;
      step();
      compared++;
      if (dif.o_switch_1 !== (e >= 10) || dif.o_sel_change !== (e == 11) || act !== model_vec()) begin
        mismatched++;
        $display("FAIL bounce edge %0d: got %b, want sw1=%b sel=%b (model %b)",
                 e, act, e >= 10, e == 11, model_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 5) == 0) drv_raw[c] = ~drv_raw[c];
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
      compared++;
      if (act !== model_vec()) begin
        mismatched++;
        $display("FAIL random cycle %0d: got %b, want %b", i, act, model_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_switch1_latency();
    test_glitch();
    test_button();
    test_both_switches();
    test_press_and_switch();
    test_reset_mid_count();
    test_bounce();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
